// File: rtl/coord_gpio_tx.sv
// coord_gpio_tx: serializes a latched X/Y pair onto a 10-bit GPIO bus, X on the strobe
// rising edge and Y on the falling edge, with programmable setup/hold spacing.
module coord_gpio_tx #(
  parameter int SETUP_CYCLES = 4,
  parameter int HOLD_CYCLES  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] i_x,
  input  logic [9:0] i_y,
  input  logic       i_valid,
  output logic       o_ready,
  output logic [9:0] o_gpio_data,
  output logic       o_gpio_strobe,
  output logic       o_frame_done
);
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] X_SETUP = 3'd1;
  localparam logic [2:0] X_HOLD  = 3'd2;
  localparam logic [2:0] Y_SETUP = 3'd3;
  localparam logic [2:0] Y_HOLD  = 3'd4;
  localparam logic [7:0] SETUP_LD = 8'(SETUP_CYCLES - 1);
  localparam logic [7:0] HOLD_LD  = 8'(HOLD_CYCLES - 1);
  logic [2:0] r_state;
  logic [7:0] r_cnt;
  logic [9:0] r_y;
  logic [9:0] r_data;
  logic       r_strobe;
  logic       r_done;
  logic       w_idle;
  logic       w_zero;
  assign w_idle        = r_state == IDLE;
  assign w_zero        = r_cnt == 8'd0;
  assign o_ready       = w_idle;
  assign o_gpio_data   = r_data;
  assign o_gpio_strobe = r_strobe;
  assign o_frame_done  = r_done;
  // each phase loads its length minus one and leaves once the counter reaches zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= 8'd0;
      r_y      <= 10'd0;
      r_data   <= 10'd0;
      r_strobe <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (!w_idle && !w_zero) r_cnt <= r_cnt - 8'd1;
      case (r_state)
        IDLE: if (i_valid) begin
          r_state <= X_SETUP;
          r_data  <= i_x;
          r_y     <= i_y;
          r_cnt   <= SETUP_LD;
        end
        X_SETUP: if (w_zero) begin
          r_state  <= X_HOLD;
          r_strobe <= 1'b1;
          r_cnt    <= HOLD_LD;
        end
        X_HOLD: if (w_zero) begin
          r_state <= Y_SETUP;
          r_data  <= r_y;
          r_cnt   <= SETUP_LD;
        end
        Y_SETUP: if (w_zero) begin
          r_state  <= Y_HOLD;
          r_strobe <= 1'b0;
          r_cnt    <= HOLD_LD;
        end
        Y_HOLD: if (w_zero) begin
          r_state <= IDLE;
          r_done  <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_coord_gpio_tx.sv
// tb_coord_gpio_tx: directed vectors for the default and the 1/1 timing variants,
// plus a loopback receiver on the default instance.
module tb_coord_gpio_tx;
  logic       clk = 0;
  logic       rst_n = 0;
  logic [9:0] x0 = 0, y0 = 0, x1 = 0, y1 = 0;
  logic       v0 = 0, v1 = 0;
  logic       rdy0, rdy1, s0, s1, f0, f1;
  logic [9:0] d0, d1;
  int         n_vec = 0, n_err = 0;
  logic [19:0] rxq[$];
  logic [9:0] rx_x = 0, pd = 0;
  logic       ps = 0;

  coord_gpio_tx dut0 (
    .clk(clk), .rst_n(rst_n), .i_x(x0), .i_y(y0), .i_valid(v0), .o_ready(rdy0),
    .o_gpio_data(d0), .o_gpio_strobe(s0), .o_frame_done(f0)
  );
  coord_gpio_tx #(.SETUP_CYCLES(1), .HOLD_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .i_x(x1), .i_y(y1), .i_valid(v1), .o_ready(rdy1),
    .o_gpio_data(d1), .o_gpio_strobe(s1), .o_frame_done(f1)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // loopback receiver: X on strobe rise, Y on strobe fall; data must not move on an edge
  always @(posedge clk) begin
    if (!rst_n) begin
      ps = 0;
      pd = 0;
    end else begin
      if (s0 != ps) begin
        chk("edge_data_stable", 32'(d0), 32'(pd));
        if (s0) rx_x = d0;
        else rxq.push_back({rx_x, d0});
      end
      ps = s0;
      pd = d0;
    end
  end

  task automatic accept(input bit u, input logic [9:0] x, input logic [9:0] y);
    int n = 0;
    if (u) begin x1 = x; y1 = y; v1 = 1; end
    else begin x0 = x; y0 = y; v0 = 1; end
    while (!(u ? rdy1 : rdy0) && n < 100) begin tick; n++; end
    chk("accept_ready", 32'(u ? rdy1 : rdy0), 32'd1);
    tick;
    v0 = 0;
    v1 = 0;
  endtask

  task automatic wait_rx(input int n);
    int i = 0;
    while (rxq.size() < n && i < 300) begin tick; i++; end
    chk("rx_count", 32'(rxq.size()), 32'(n));
  endtask

  typedef struct {
    bit         u;
    int         k;
    logic [9:0] d;
    logic       s;
    logic       f;
    logic       r;
  } vec_t;
  vec_t vt[16];

  initial begin
    int k, extra, na;
    int acc_cyc[3];
    logic [9:0] px[3], py[3];
    logic [9:0] ad;
    logic as, af, ar;
    vt[0]  = '{0, 1,  10'h155, 0, 0, 0};
    vt[1]  = '{0, 4,  10'h155, 0, 0, 0};
    vt[2]  = '{0, 5,  10'h155, 1, 0, 0};
    vt[3]  = '{0, 8,  10'h155, 1, 0, 0};
    vt[4]  = '{0, 9,  10'h2AA, 1, 0, 0};
    vt[5]  = '{0, 12, 10'h2AA, 1, 0, 0};
    vt[6]  = '{0, 13, 10'h2AA, 0, 0, 0};
    vt[7]  = '{0, 16, 10'h2AA, 0, 0, 0};
    vt[8]  = '{0, 17, 10'h2AA, 0, 1, 1};
    vt[9]  = '{0, 18, 10'h2AA, 0, 0, 1};
    vt[10] = '{1, 1,  10'd5,   0, 0, 0};
    vt[11] = '{1, 2,  10'd5,   1, 0, 0};
    vt[12] = '{1, 3,  10'd7,   1, 0, 0};
    vt[13] = '{1, 4,  10'd7,   0, 0, 0};
    vt[14] = '{1, 5,  10'd7,   0, 1, 1};
    vt[15] = '{1, 6,  10'd7,   0, 0, 1};
    px[0] = 10'd10;   py[0] = 10'd20;
    px[1] = 10'd639;  py[1] = 10'd479;
    px[2] = 10'd1023; py[2] = 10'd0;

    #3;
    chk("rst_data", 32'(d0), 32'd0);
    chk("rst_strobe", 32'(s0), 32'd0);
    chk("rst_done", 32'(f0), 32'd0);
    tick;
    tick;
    rst_n = 1;
    chk("rst_ready", 32'(rdy0), 32'd1);

    k = 1;
    for (int i = 0; i < 16; i++) begin
      if (i == 0) begin accept(0, 10'h155, 10'h2AA); k = 1; end
      if (i == 10) begin accept(1, 10'd5, 10'd7); k = 1; end
      while (k < vt[i].k) begin tick; k++; end
      ad = vt[i].u ? d1 : d0;
      as = vt[i].u ? s1 : s0;
      af = vt[i].u ? f1 : f0;
      ar = vt[i].u ? rdy1 : rdy0;
      chk($sformatf("vec%0d_data", i), 32'(ad), 32'(vt[i].d));
      chk($sformatf("vec%0d_strobe", i), 32'(as), 32'(vt[i].s));
      chk($sformatf("vec%0d_done", i), 32'(af), 32'(vt[i].f));
      chk($sformatf("vec%0d_ready", i), 32'(ar), 32'(vt[i].r));
      if (i == 9) begin
        chk("single_rx_pair", 32'(rxq.size() > 0 ? rxq[0] : 20'hFFFFF), 32'({10'h155, 10'h2AA}));
        for (int c = 0; c < 100; c++) begin
          chk("idle_data", 32'(d0), 32'h2AA);
          chk("idle_strobe", 32'(s0), 32'd0);
          chk("idle_done", 32'(f0), 32'd0);
          tick;
        end
      end
    end

    rxq.delete();
    v0 = 1; x0 = px[0]; y0 = py[0];
    na = 0;
    for (int cyc = 0; cyc < 120 && na < 3; cyc++) begin
      bit acc;
      acc = rdy0 && v0;
      tick;
      if (acc) begin
        acc_cyc[na] = cyc;
        na++;
        if (na < 3) begin x0 = px[na]; y0 = py[na]; end
        else v0 = 0;
      end
    end
    v0 = 0;
    chk("b2b_accepts", 32'(na), 32'd3);
    if (na == 3) begin
      chk("b2b_acc0", 32'(acc_cyc[0]), 32'd0);
      chk("b2b_acc1", 32'(acc_cyc[1]), 32'd17);
      chk("b2b_acc2", 32'(acc_cyc[2]), 32'd34);
    end
    wait_rx(3);
    for (int i = 0; i < 3; i++)
      if (rxq.size() > i) chk($sformatf("b2b_pair%0d", i), 32'(rxq[i]), 32'({px[i], py[i]}));

    rxq.delete();
    accept(0, 10'h3C3, 10'h0F0);
    extra = 0;
    for (int c = 1; c <= 16; c++) begin
      x0 = 10'($urandom);
      y0 = 10'($urandom);
      v0 = c[0];
      if (rdy0 && v0) extra++;
      tick;
    end
    v0 = 0;
    chk("busy_extra_accepts", 32'(extra), 32'd0);
    wait_rx(1);
    if (rxq.size() > 0) chk("busy_pair", 32'(rxq[0]), 32'({10'h3C3, 10'h0F0}));
    chk("busy_last_y", 32'(d0), 32'h0F0);

    rxq.delete();
    accept(0, 10'h1A5, 10'h05A);
    k = 1;
    while (k < 7) begin tick; k++; end
    chk("pre_rst_strobe", 32'(s0), 32'd1);
    chk("pre_rst_data", 32'(d0), 32'h1A5);
    #2;
    rst_n = 0;
    #1;
    chk("mid_rst_strobe", 32'(s0), 32'd0);
    chk("mid_rst_data", 32'(d0), 32'd0);
    chk("mid_rst_done", 32'(f0), 32'd0);
    tick;
    tick;
    rst_n = 1;
    chk("post_rst_ready", 32'(rdy0), 32'd1);
    accept(0, 10'h2F0, 10'h10F);
    wait_rx(1);
    if (rxq.size() > 0) chk("post_rst_pair", 32'(rxq[0]), 32'({10'h2F0, 10'h10F}));
    tick;
    tick;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/coord_gpio_tx.md
# coord_gpio_tx

Transmit side of the two-phase GPIO coordinate link. Takes a 10-bit X/Y coordinate pair over a valid/ready handshake and serializes it onto a 10-bit data bus plus one phase strobe.

- A rising strobe edge marks X as valid on the bus.
- The following falling strobe edge marks Y as valid.

Used on boards acting as coordinate source, and in loopback benches driving our coordinate receiver.

## Interface
- SETUP_CYCLES, 4, clk cycles data is stable before each strobe edge; legal range 1..255
- HOLD_CYCLES, 4, clk cycles data is held after each strobe edge; legal range 1..255
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- in_x  in  10  X coordinate, sampled on accept
- in_y  in  10  Y coordinate, sampled on accept
- in_valid  in  1  source has a coordinate pair
- in_ready  out  1  block can accept; pair accepted when in_valid & in_ready at a rising clk edge
- gpio_data  out  10  coordinate bus, maps to GPIO[9:0]
- gpio_strobe  out  1  phase strobe, maps to GPIO[10]
- frame_done  out  1  one-cycle pulse after the Y hold completes

## Operation
- All outputs are registered. in_ready is the only exception: it is a decode of state == IDLE.
- Reset values: gpio_data = 0, gpio_strobe = 0, frame_done = 0, state = IDLE, in_ready = 1 once reset is released.
- Accept: in_x/in_y are latched into internal registers. Later input changes have no effect on the frame in flight.
- States and transitions:
  - IDLE -> X_SETUP on accept. gpio_data <= x at the transition.
  - X_SETUP: count SETUP_CYCLES, then -> X_HOLD with gpio_strobe <= 1.
  - X_HOLD: count HOLD_CYCLES, then -> Y_SETUP with gpio_data <= y.
  - Y_SETUP: count SETUP_CYCLES, then -> Y_HOLD with gpio_strobe <= 0.
  - Y_HOLD: count HOLD_CYCLES, then -> IDLE with frame_done <= 1 for one cycle.
- Phase counter: width $clog2(256) = 8 bits, down-counting. Loaded with PARAM-1 on entry to each state; the state exits when the counter is 0.
- gpio_data keeps the last Y value in IDLE. It changes only on accept or at the X_HOLD->Y_SETUP transition.
- gpio_strobe is low in IDLE, X_SETUP and Y_HOLD; high in X_HOLD and Y_SETUP. The block never produces a glitch or more than two edges per frame.
- in_valid while busy is ignored and the pair is not queued. The source keeps in_valid asserted until accepted.
- No arithmetic on coordinates. All 10 bits pass through unmodified, including values above 639/479.

## Timing
- Timing is counted from the accept edge at cycle T, with S = SETUP_CYCLES and H = HOLD_CYCLES.
- Frame schedule:
  - gpio_data = x from T+1
  - gpio_strobe rises at T+1+S
  - gpio_data = y from T+1+S+H
  - gpio_strobe falls at T+1+2S+H
  - frame_done high in cycle T+1+2S+2H
  - in_ready high from T+1+2S+2H
- Back-to-back: in_valid held high gives the next accept at T+1+2S+2H, so the frame period is 1+2S+2H cycles. With defaults: 17.
- Data never changes in the same cycle as a strobe edge. Minimum setup and hold margins are 1 clk each.
- Reset asserted mid-frame:
  - All outputs go to reset values immediately (asynchronous).
  - If gpio_strobe was high, the receiver sees a falling edge with data 0 and latches Y = 0. This is accepted behaviour: the downstream filters a (x, 0) pair after reset.
- Reset release: the first accept is possible at the first clk rising edge with reset high.

## Test plan
- Defaults, single pair x=0x155, y=0x2AA accepted at T=0 -> gpio_data 0x155 at 1; strobe rises at 5; gpio_data 0x2AA at 9; strobe falls at 13; frame_done at 17; in_ready high at 17.
- Back-to-back pairs (10,20), (639,479), (1023,0) with in_valid held -> accepts at 0, 17, 34. Loopback receiver reports exactly these three pairs, in order.
- SETUP_CYCLES=1, HOLD_CYCLES=1, x=5, y=7 -> strobe rises at T+2, data=7 at T+3, strobe falls at T+4, frame_done at T+5. Data is never coincident with a strobe edge.
- in_x/in_y changed every cycle during a frame, with in_valid pulsed while busy -> the transmitted pair equals the accepted values, and there are no extra accepts.
- Reset asserted at T+7 (strobe high) -> same-cycle gpio_strobe = 0, gpio_data = 0, in_ready = 1 after release. The next frame transmits correctly.
- Idle with in_valid low for 100 cycles after a frame -> gpio_data holds the last Y, strobe stays 0, frame_done stays 0.
